uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: serial line, FIFO read port and status pulses.
// The master drives rx/ren and observes the rest; the slave is the receiver itself.
interface uart_rx_fifo_if;
    logic       rx;
    logic       ren;
    logic [7:0] fo;
    logic       full;
    logic       empty;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx, ren,
        input  fo, full, empty, frame_err, overrun
    );

    modport slave (
        input  rx, ren,
        output fo, full, empty, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO with a registered read port.
// Frame errors and dropped bytes are reported as one-cycle pulses.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DEPTH        = 16
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [15:0]      CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]      CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       fo_q, fo_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic [7:0] mem [DEPTH];
    logic       rxs, push, pop, wr_en, full, empty;

    assign rxs   = sync2_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        sync1_d     = bus.rx;
        sync2_d     = sync1_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    push        = rxs;
                    frame_err_d = !rxs;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands
    always_comb begin
        pop       = bus.ren && !empty;
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        wptr_d    = wptr_q + PTR_W'(wr_en);
        rptr_d    = rptr_q + PTR_W'(pop);
        fo_d      = pop ? mem[rptr_q] : fo_q;
        count_d   = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            fo_q        <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            fo_q        <= fo_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage is not reset; stale bytes are hidden behind empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= shift_q;
    end

    assign bus.fo        = fo_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule
